// File: rtl/sdram_rcache_pkg.sv
// rtl/sdram_rcache_pkg.sv - shared widths and FSM encoding for sdram_rcache
package sdram_rcache_pkg;
    localparam int ADDR_W = 22;
    localparam int IDX_W  = 8;
    localparam int TAG_W  = 14;
    localparam int LINES  = 256;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT
    } rc_state_t;
endpackage

// File: rtl/sdram_rcache_ram.sv
// rtl/sdram_rcache_ram.sv - single-clock 1R/1W synchronous RAM used for the cache arrays
module rcache_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sdram_rcache.sv
// rtl/sdram_rcache.sv - direct-mapped write-through read cache in front of an SDRAM controller
// Optional hit/miss statistics counters are built when RCACHE_STATS_EN is defined.
module sdram_rcache
    import sdram_rcache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] up_addr,
    input  logic [31:0] up_data_in,
    input  logic        up_req,
    input  logic        up_write,
    output logic [31:0] up_data_out,
    output logic        up_done,
    output logic        up_ready,
    output logic [21:0] sdram_addr,
    output logic [31:0] sdram_data_out,
    output logic        sdram_req,
    output logic        sdram_write,
    input  logic [31:0] sdram_data_in,
    input  logic        sdram_done,
    input  logic        sdram_ready,
    input  logic        flush,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    rc_state_t         r_state;
    logic [IDX_W-1:0]  r_init_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_write;
    logic              r_hit_done;
    logic [31:0]       r_hit_data;
    logic [ADDR_W-1:0] r_sdram_addr;
    logic [31:0]       r_sdram_data;

    logic [TAG_W:0]    w_tag_rd;
    logic [31:0]       w_data_rd;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_hit;
    logic              w_done_rd;
    logic              w_done_wr;
    logic              w_tag_we;
    logic [IDX_W-1:0]  w_tag_waddr;
    logic [TAG_W:0]    w_tag_wdata;
    logic              w_data_we;
    logic [31:0]       w_data_wdata;

    assign w_idx     = r_addr[IDX_W-1:0];
    // RAMs are addressed from the live bus in IDLE so the line is ready in LOOKUP
    assign w_rd_idx  = (r_state == ST_IDLE) ? up_addr[IDX_W-1:0] : w_idx;
    assign w_hit     = w_tag_rd[TAG_W] && (w_tag_rd[TAG_W-1:0] == r_addr[ADDR_W-1:IDX_W]);
    assign w_done_rd = !reset && (r_state == ST_RD_WAIT) && sdram_done;
    assign w_done_wr = !reset && (r_state == ST_WR_WAIT) && sdram_done;

    assign w_tag_we     = (r_state == ST_INIT) || w_done_rd;
    assign w_tag_waddr  = (r_state == ST_INIT) ? r_init_cnt : w_idx;
    assign w_tag_wdata  = (r_state == ST_INIT) ? '0 : {1'b1, r_addr[ADDR_W-1:IDX_W]};
    assign w_data_we    = w_done_rd || ((r_state == ST_LOOKUP) && r_write && w_hit);
    assign w_data_wdata = w_done_rd ? sdram_data_in : r_data;

    rcache_ram #(.WIDTH(32), .DEPTH(LINES)) u_data_ram (
        .clk     (clk),
        .i_we    (w_data_we),
        .i_waddr (w_idx),
        .i_wdata (w_data_wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_data_rd)
    );

    rcache_ram #(.WIDTH(TAG_W + 1), .DEPTH(LINES)) u_tag_ram (
        .clk     (clk),
        .i_we    (w_tag_we),
        .i_waddr (w_tag_waddr),
        .i_wdata (w_tag_wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_tag_rd)
    );

    assign up_ready       = !reset && (r_state == ST_IDLE);
    assign sdram_req      = !reset && sdram_ready &&
                            ((r_state == ST_RD_REQ) || (r_state == ST_WR_REQ));
    assign sdram_write    = sdram_req && (r_state == ST_WR_REQ);
    assign sdram_addr     = r_sdram_addr;
    assign sdram_data_out = r_sdram_data;
    assign up_done        = r_hit_done || w_done_rd || w_done_wr;
    assign up_data_out    = r_hit_done ? r_hit_data : (w_done_rd ? sdram_data_in : 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_hit_done   <= 1'b0;
            r_hit_data   <= '0;
            r_sdram_addr <= '0;
            r_sdram_data <= '0;
        end else begin
            r_hit_done <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == IDX_W'(LINES - 1))
                        r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (flush) begin
                        r_state    <= ST_INIT;
                        r_init_cnt <= '0;
                    end else if (up_req) begin
                        r_addr  <= up_addr;
                        r_data  <= up_data_in;
                        r_write <= up_write;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!r_write && w_hit) begin
                        r_hit_done <= 1'b1;
                        r_hit_data <= w_data_rd;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_sdram_addr <= r_addr;
                        r_sdram_data <= r_data;
                        r_state      <= r_write ? ST_WR_REQ : ST_RD_REQ;
                    end
                end
                ST_RD_REQ:  if (sdram_ready) r_state <= ST_RD_WAIT;
                ST_RD_WAIT: if (sdram_done)  r_state <= ST_IDLE;
                ST_WR_REQ:  if (sdram_ready) r_state <= ST_WR_WAIT;
                ST_WR_WAIT: if (sdram_done)  r_state <= ST_IDLE;
                default:    r_state <= ST_INIT;
            endcase
        end
    end

`ifdef RCACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if ((r_state == ST_LOOKUP) && !r_write) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF)
                    r_hit_cnt <= r_hit_cnt + 1'b1;
            end else if (r_miss_cnt != 16'hFFFF) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif
endmodule

// File: tb/tb_sdram_rcache.sv
// tb/tb_sdram_rcache.sv - self-checking bench for sdram_rcache with a behavioural controller and cache model
module tb_sdram_rcache;
    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] up_addr;
    logic [31:0] up_data_in;
    logic        up_req;
    logic        up_write;
    logic [31:0] up_data_out;
    logic        up_done;
    logic        up_ready;
    logic [21:0] sdram_addr;
    logic [31:0] sdram_data_out;
    logic        sdram_req;
    logic        sdram_write;
    logic [31:0] sdram_data_in;
    logic        sdram_done;
    logic        sdram_ready;
    logic        flush;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    sdram_rcache dut (
        .clk            (clk),
        .reset          (reset),
        .up_addr        (up_addr),
        .up_data_in     (up_data_in),
        .up_req         (up_req),
        .up_write       (up_write),
        .up_data_out    (up_data_out),
        .up_done        (up_done),
        .up_ready       (up_ready),
        .sdram_addr     (sdram_addr),
        .sdram_data_out (sdram_data_out),
        .sdram_req      (sdram_req),
        .sdram_write    (sdram_write),
        .sdram_data_in  (sdram_data_in),
        .sdram_done     (sdram_done),
        .sdram_ready    (sdram_ready),
        .flush          (flush),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit [31:0]   ctl_mem [int];
    bit [31:0]   ref_mem [int];
    int          line_addr [256];
    int          ctl_lat = 5;
    int          ctl_cnt = 0;
    logic [31:0] ctl_rdata;
    int          req_count = 0;
    logic [21:0] last_addr;
    logic [31:0] last_wdata;
    logic        last_write;
    int          done_total = 0;
    int          bad_zero = 0;
    int          bad_rdy = 0;
    int          exp_hits = 0;
    int          exp_miss = 0;

    function automatic logic [31:0] dflt(input logic [21:0] a);
        return {a[9:0], a} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [21:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    function automatic void invalidate_model();
        foreach (line_addr[i]) line_addr[i] = -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef RCACHE_STATS_EN
        chk({tag, "_hits"}, 64'(hit_count), 64'(exp_hits));
        chk({tag, "_miss"}, 64'(miss_count), 64'(exp_miss));
`else
        chk({tag, "_hits"}, 64'(hit_count), 64'd0);
        chk({tag, "_miss"}, 64'(miss_count), 64'd0);
`endif
    endtask

    // SDRAM controller: accepts a strobe, goes busy, returns done after ctl_lat cycles
    initial begin
        sdram_ready   = 1'b1;
        sdram_done    = 1'b0;
        sdram_data_in = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            sdram_done    = 1'b0;
            sdram_data_in = 32'd0;
            if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    sdram_done    = 1'b1;
                    sdram_data_in = ctl_rdata;
                    sdram_ready   = 1'b1;
                end else begin
                    sdram_ready = 1'b0;
                end
            end else if (sdram_req) begin
                req_count++;
                last_addr  = sdram_addr;
                last_write = sdram_write;
                last_wdata = sdram_data_out;
                if (sdram_write)
                    ctl_mem[int'(sdram_addr)] = sdram_data_out;
                ctl_rdata = ctl_mem.exists(int'(sdram_addr)) ? ctl_mem[int'(sdram_addr)] : dflt(sdram_addr);
                ctl_cnt   = ctl_lat;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (up_done) done_total++;
            if (!up_done && up_data_out !== 32'd0) bad_zero++;
            if (sdram_req && !sdram_ready) bad_rdy++;
        end
    end

    task automatic count_init(output int n);
        n = 0;
        while (!up_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic access(input logic wr, input logic [21:0] a, input logic [31:0] d,
                          input int lat, input string tag);
        int          req0;
        int          cyc;
        int          w;
        logic        hit;
        logic [31:0] got;
        logic        sd;
        ctl_lat = lat;
        w = 0;
        while (!up_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) chk({tag, "_ready_timeout"}, 64'(up_ready), 64'd1);
        req0       = req_count;
        hit        = !wr && (line_addr[a[7:0]] == int'(a));
        up_req     = 1'b1;
        up_write   = wr;
        up_addr    = a;
        up_data_in = d;
        @(negedge clk);
        up_req   = 1'b0;
        up_write = 1'b0;
        cyc = 1;
        while (!up_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        got = up_data_out;
        sd  = sdram_done;
        chk({tag, "_lat"}, 64'(cyc), hit ? 64'd2 : 64'(2 + lat));
        chk({tag, "_nreq"}, 64'(req_count - req0), hit ? 64'd0 : 64'd1);
        if (!wr) chk({tag, "_data"}, 64'(got), 64'(ref_rd(a)));
        if (!hit) chk({tag, "_sdone"}, 64'(sd), 64'd1);
        if (wr) begin
            chk({tag, "_wdir"}, 64'(last_write), 64'd1);
            chk({tag, "_waddr"}, 64'(last_addr), 64'(a));
            chk({tag, "_wdata"}, 64'(last_wdata), 64'(d));
            ref_mem[int'(a)] = d;
        end else if (hit) begin
            exp_hits++;
        end else begin
            chk({tag, "_rdir"}, 64'(last_write), 64'd0);
            chk({tag, "_raddr"}, 64'(last_addr), 64'(a));
            exp_miss++;
            line_addr[a[7:0]] = int'(a);
        end
        @(negedge clk);
    endtask

    initial begin
        int          n;
        int          d0;
        int          r0;
        logic [21:0] ra;
        logic        rw;
        logic [7:0]  idx_pool [5];
        logic [13:0] tag_pool [3];

        idx_pool = '{8'h00, 8'h10, 8'h11, 8'hF0, 8'hFF};
        tag_pool = '{14'h0012, 14'h0022, 14'h3FFF};
        reset      = 1'b1;
        up_req     = 1'b0;
        up_write   = 1'b0;
        up_addr    = '0;
        up_data_in = '0;
        flush      = 1'b0;
        invalidate_model();

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(up_ready), 64'd0);
        chk("rst_done", 64'(up_done), 64'd0);
        chk("rst_sreq", 64'(sdram_req), 64'd0);
        chk("rst_swrite", 64'(sdram_write), 64'd0);
        chk("rst_saddr", 64'(sdram_addr), 64'd0);
        chk("rst_sdata", 64'(sdram_data_out), 64'd0);
        chk("rst_dout", 64'(up_data_out), 64'd0);
        chk_stats("rst");

        reset = 1'b0;
        r0 = req_count;
        count_init(n);
        chk("init_len", 64'(n), 64'd256);
        chk("init_noreq", 64'(req_count - r0), 64'd0);

        ctl_mem[32'h001234] = 32'hDEADBEEF;
        ref_mem[32'h001234] = 32'hDEADBEEF;
        access(1'b0, 22'h001234, 32'd0, 5, "cold_rd");
        chk_stats("cold");
        access(1'b0, 22'h001234, 32'd0, 5, "hit_rd");
        chk_stats("hit");
        access(1'b1, 22'h001234, 32'h12345678, 3, "wr_hit");
        access(1'b0, 22'h001234, 32'd0, 3, "rd_after_wr");
        access(1'b0, 22'h002234, 32'd0, 2, "conflict_rd");
        access(1'b0, 22'h001234, 32'd0, 4, "evicted_rd");
        access(1'b1, 22'h003300, 32'hCAFE0001, 1, "wr_miss");
        access(1'b0, 22'h003300, 32'd0, 1, "rd_wr_miss");

        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        r0 = req_count;
        count_init(n);
        invalidate_model();
        chk("flush_len", 64'(n), 64'd256);
        chk("flush_noreq", 64'(req_count - r0), 64'd0);
        access(1'b0, 22'h001234, 32'd0, 2, "post_flush_rd");

        d0 = done_total;
        r0 = req_count;
        flush      = 1'b1;
        up_req     = 1'b1;
        up_write   = 1'b0;
        up_addr    = 22'h001234;
        @(negedge clk);
        flush  = 1'b0;
        up_req = 1'b0;
        count_init(n);
        invalidate_model();
        chk("flush_req_len", 64'(n), 64'd256);
        chk("flush_req_nodone", 64'(done_total - d0), 64'd0);
        chk("flush_req_noreq", 64'(req_count - r0), 64'd0);

        ctl_lat    = 8;
        up_req     = 1'b1;
        up_write   = 1'b0;
        up_addr    = 22'h0000AB;
        @(negedge clk);
        up_req = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_total;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_init(n);
        invalidate_model();
        exp_hits = 0;
        exp_miss = 0;
        chk("midrst_len", 64'(n), 64'd256);
        chk("midrst_nodone", 64'(done_total - d0), 64'd0);
        chk_stats("midrst");

        for (int i = 0; i < 150; i++) begin
            ra = {tag_pool[$urandom_range(0, 2)], idx_pool[$urandom_range(0, 4)]};
            rw = ($urandom_range(0, 9) < 3);
            access(rw, ra, $urandom, int'($urandom_range(1, 4)), $sformatf("rand%0d", i));
        end
        chk_stats("final");
        chk("dout_zero_when_idle", 64'(bad_zero), 64'd0);
        chk("sreq_only_when_ready", 64'(bad_rdy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_rcache.md
SDRAM_RCACHE -- requirements
Module: sdram_rcache

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 up_addr  input  22  word address from the bus interface DRAM port.
REQ-005 up_data_in  input  32  write data from the bus interface.
REQ-006 up_req  input  1  request strobe; accepted when up_req & up_ready.
REQ-007 up_write  input  1  1 = write, 0 = read; sampled with up_req.
REQ-008 up_data_out  output  32  read data; valid in the up_done cycle.
REQ-009 up_done  output  1  one-cycle completion pulse.
REQ-010 up_ready  output  1  block can accept a request this cycle.
REQ-011 sdram_addr, sdram_data_out  output  22, 32  controller address and write data.
REQ-012 sdram_req, sdram_write  output  1, 1  controller strobe and direction; sdram_req is a one-cycle pulse issued only while sdram_ready=1.
REQ-013 sdram_data_in, sdram_done, sdram_ready  input  32, 1, 1  controller read data, completion pulse, and idle status.
REQ-014 flush  input  1  invalidate-all request; level-sampled in IDLE.
REQ-015 hit_count, miss_count  output  16, 16  statistics counters (see Configuration).

Function
REQ-016 SHALL be a direct-mapped, write-through, read-allocate cache with 256 one-word lines: index = up_addr[7:0], tag = up_addr[21:8], plus one valid bit per line.
REQ-017 FSM states SHALL be INIT, IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-018 up_ready SHALL be 1 only in IDLE.
REQ-019 Accepting a request in IDLE SHALL register addr, data, and write, then move to LOOKUP; tag RAM and data RAM are read synchronously.
REQ-020 A read hit (LOOKUP, valid & tag match) SHALL pulse up_done with the cached word and return to IDLE: 2 cycles from acceptance to up_done.
REQ-021 A read miss SHALL go to RD_REQ, wait for sdram_ready, pulse sdram_req with sdram_write=0, then move to RD_WAIT.
REQ-022 In RD_WAIT, on sdram_done, the block SHALL write the line (data, tag, valid=1), pulse up_done with up_data_out = sdram_data_in in that same cycle, and go to IDLE.
REQ-023 A write SHALL always go to WR_REQ then WR_WAIT (write-through); on a hit the line data SHALL be updated in LOOKUP; on a miss nothing is allocated.
REQ-024 In WR_WAIT, sdram_done SHALL produce an up_done pulse and a return to IDLE.
REQ-025 flush=1 in IDLE SHALL take priority over up_req and enter INIT.
REQ-026 INIT SHALL clear one valid bit per cycle for indexes 0..255 (8-bit counter) and exit to IDLE after index 255: 256 cycles with up_ready=0.
REQ-027 sdram_addr and sdram_data_out SHALL hold the registered request values from RD_REQ/WR_REQ until sdram_done.
REQ-028 sdram_done outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-029 up_data_out SHALL be 0 when up_done=0.

Reset
REQ-030 Reset SHALL force state=INIT with init counter=0; outputs are up_done=0, up_ready=0, sdram_req=0, sdram_write=0, sdram_addr=0, sdram_data_out=0, up_data_out=0, and counters=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no up_done, then execute a full invalidate; a late sdram_done is ignored per REQ-028.

Configuration
REQ-032 With RCACHE_STATS_EN defined, hit_count SHALL increment on each read hit and miss_count on each read miss, both saturating at 16'hFFFF and cleared only by reset.
REQ-033 Without RCACHE_STATS_EN, hit_count and miss_count SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-034 A shared package SHALL hold the index/tag widths (8, 14), the line count (256), and the FSM state encodings.
REQ-035 One sub-module, rcache_ram, SHALL be a parameterised single-clock, one-read/one-write synchronous RAM; it SHALL be instantiated for the data array (32 bits) and for the tag+valid array (15 bits).

Verification
REQ-036 After reset: up_ready=0 for exactly 256 cycles, then 1; no sdram_req is issued during that period.
REQ-037 Read 0x001234 (cold), controller returns 0xDEADBEEF 5 cycles after the request: exactly one sdram_req, and up_done with 0xDEADBEEF in the sdram_done cycle; miss_count=1.
REQ-038 Repeat the read of 0x001234: up_done 2 cycles after acceptance with 0xDEADBEEF, and no sdram_req; hit_count=1.
REQ-039 Write 0x12345678 to 0x001234, then read it: the write issues sdram_req with sdram_write=1 and addr 0x001234; the read hits and returns 0x12345678.
REQ-040 Read 0x002234 (same index, different tag): a miss, the line is replaced, and a following read of 0x001234 misses again.
REQ-041 Pulse flush while a line is valid: INIT lasts 256 cycles, and the next read of that address misses. A flush and an up_req in the same IDLE cycle: the flush wins and the request is not accepted.
